// File: rtl/adc_pulse_gen_pkg.sv
// Shared ADC sample-stream definitions: sample width, pulse FSM states, saturating add.
// Pure declarations; no timing and no flow control.
package adc_pulse_gen_pkg;

  localparam int SIZE_ADC_DATA = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RISE  = 2'd1,
    DECAY = 2'd2
  } pulse_state_e;

  // Unsigned add clamped to max_val; callers zero-extend into 32 bits and cast the result back.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/adc_pulse_env.sv
// Pulse envelope engine: linear rise over 2^RISE_SHIFT samples, exponential decay to zero.
// Envelope updates on the edge that samples start; start is never back-pressured (dropped during RISE).
module adc_pulse_env #(
  parameter int SIZE_ADC_DATA = adc_pulse_gen_pkg::SIZE_ADC_DATA,
  parameter int RISE_SHIFT    = 2,
  parameter int DECAY_SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic [SIZE_ADC_DATA:0]   env,
  output logic                     busy,
  output logic                     pulse_done,
  output logic                     start_drop
);
  import adc_pulse_gen_pkg::*;

  localparam int                 ENV_W       = SIZE_ADC_DATA + 1;
  localparam int                 CNT_W       = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
  localparam logic [31:0]        ENV_MAX     = (32'd1 << ENV_W) - 32'd1;
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'((1 << RISE_SHIFT) - 1);
  localparam logic [ENV_W-1:0]   DECAY_FLOOR = ENV_W'(1 << DECAY_SHIFT);

  pulse_state_e             state_q, state_d;
  logic [ENV_W-1:0]         env_q, env_d;
  logic [ENV_W-1:0]         target_q, target_d;
  logic [SIZE_ADC_DATA-1:0] inc_q, inc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;

  logic                     accept;
  logic                     rise_last;
  logic                     decay_end;
  logic [ENV_W-1:0]         base_env;
  logic [SIZE_ADC_DATA-1:0] new_inc;

  assign accept    = start && (state_q != RISE);
  assign rise_last = (state_q == RISE) && (cnt_q >= CNT_LAST);
  assign decay_end = (state_q == DECAY) && (env_q < DECAY_FLOOR);
  // A start on the terminating DECAY cycle stacks on the zeroed envelope, not the residue.
  assign base_env  = decay_end ? '0 : env_q;
  assign new_inc   = amplitude >> RISE_SHIFT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      env_q    <= '0;
      target_q <= '0;
      inc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      target_q <= target_d;
      inc_q    <= inc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RISE;
      RISE:    if (rise_last) state_d = DECAY;
      DECAY: begin
        if (start) begin
          state_d = RISE;
        end else if (decay_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    env_d    = env_q;
    target_d = target_q;
    inc_d    = inc_q;
    cnt_d    = cnt_q;
    done_d   = decay_end;
    if (accept) begin
      // The accepting edge already applies the first ramp step, so the counter restarts at one.
      inc_d    = new_inc;
      target_d = ENV_W'(sat_add(32'(base_env), 32'(amplitude), ENV_MAX));
      env_d    = ENV_W'(sat_add(32'(base_env), 32'(new_inc), ENV_MAX));
      cnt_d    = CNT_W'(1);
    end else if (state_q == RISE) begin
      if (rise_last) begin
        env_d = target_q;
      end else begin
        env_d = ENV_W'(sat_add(32'(env_q), 32'(inc_q), ENV_MAX));
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (decay_end) begin
      env_d = '0;
    end else if (state_q == DECAY) begin
      env_d = env_q - (env_q >> DECAY_SHIFT);
    end
  end

  always_comb begin
    env        = env_q;
    busy       = (state_q != IDLE);
    pulse_done = done_q;
    start_drop = start && (state_q == RISE);
  end

endmodule

// File: rtl/adc_pulse_gen.sv
// Synthetic ADC source: baseline plus pulse envelope, clamped and registered; one sample per clk.
// Start-to-first-changed-sample is two edges; no back-pressure, starts during a rise are counted as drops.
module adc_pulse_gen #(
  parameter int SIZE_ADC_DATA = adc_pulse_gen_pkg::SIZE_ADC_DATA,
  parameter int RISE_SHIFT    = 2,
  parameter int DECAY_SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     busy,
  output logic                     pulse_done,
  output logic [7:0]               drop_count
);
  import adc_pulse_gen_pkg::*;

  localparam logic [SIZE_ADC_DATA+1:0] OUT_MAX = {2'b00, {SIZE_ADC_DATA{1'b1}}};

  logic [SIZE_ADC_DATA:0]   env;
  logic                     start_drop;
  logic [SIZE_ADC_DATA+1:0] out_sum;
  logic [SIZE_ADC_DATA-1:0] output_data_q, output_data_d;
  logic [7:0]               drop_count_q, drop_count_d;

  adc_pulse_env #(
    .SIZE_ADC_DATA (SIZE_ADC_DATA),
    .RISE_SHIFT    (RISE_SHIFT),
    .DECAY_SHIFT   (DECAY_SHIFT)
  ) u_env (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .amplitude  (amplitude),
    .env        (env),
    .busy       (busy),
    .pulse_done (pulse_done),
    .start_drop (start_drop)
  );

  always_comb begin
    // Two guard bits so baseline + saturated envelope can never wrap before the clamp.
    out_sum       = {2'b00, baseline} + {1'b0, env};
    output_data_d = (out_sum > OUT_MAX) ? '1 : out_sum[SIZE_ADC_DATA-1:0];
    drop_count_d  = 8'(sat_add(32'(drop_count_q), {31'd0, start_drop}, 32'd255));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_data_q <= '0;
      drop_count_q  <= '0;
    end else begin
      output_data_q <= output_data_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign output_data = output_data_q;
  assign drop_count  = drop_count_q;

endmodule
